pwm_ccr_out: RTL and testbench
==============================

// Module: pwm_ccr_out
// PURPOSE
//  Compare/output stage fed by the 7-bit timer/counter: consumes TCR[6:0] and the period-start flag E.
//  Buffers a duty request via valid/ready handshake, commits it to the active compare register (CCR)
//  only at a period boundary (glitch-free duty change), optionally slews CCR toward target, drives PWM.
// PARAMETERS
//  WIDTH     7  counter/duty width; period = 2**WIDTH CLK cycles
//  STEP_MAX  8  max |CCR change| per period when slewing (1..2**WIDTH-1)
//  INVERT    0  1 = PWM output active-low
// PORTS
//  CLK          in   1      system clock, rising edge
//  RST          in   1      synchronous, active-high reset
//  TCR          in   WIDTH  free-running count from timer/counter, 0..2**WIDTH-1, wraps
//  E            in   1      period-start flag from timer/counter (high while TCR==0)
//  DUTY_IN      in   WIDTH  requested duty, counts high per period
//  DUTY_VALID   in   1      DUTY_IN valid
//  DUTY_READY   out  1      pending slot empty; transfer when VALID&READY at CLK edge
//  SLEW_EN      in   1      1 = ramp CCR by <=STEP_MAX per period; 0 = jump to target
//  CCR          out  WIDTH  active compare value
//  PWM          out  1      modulated output
//  BUSY         out  1      CCR != target (ramp in progress)
//  PERIOD_DONE  out  1      one-cycle pulse per detected period boundary
// BEHAVIOUR
//  Reset (RST high at CLK edge): CCR=0, target=0, pending empty, DUTY_READY=1, PWM=INVERT,
//   BUSY=0, PERIOD_DONE=0, state=SYNC. Reset mid-period discards pending request and ramp.
//  Boundary: E sampled high this edge, low previous edge (registered edge detect). E stuck high
//   = one boundary only. PERIOD_DONE asserts the cycle after detection, for exactly one cycle.
//  Handshake: VALID&READY -> DUTY_IN into pending, READY drops next cycle. VALID w/ READY low ignored,
//   no effect; requester must hold. READY returns 1 the cycle after pending is consumed.
//  Pending consumed at boundary: target<=pending. A transfer on the same edge as a boundary is NOT
//   consumed; it waits for the next boundary. Boundary with pending empty: target unchanged.
//  States (registered, one-hot or encoded per package):
//   SYNC: after reset; PWM held inactive; first boundary -> RUN (and applies pending if any).
//   RUN : CCR==target. At boundary: new target; SLEW_EN=0 or |target-CCR|<=STEP_MAX -> CCR=target,
//         stay RUN; else CCR moves STEP_MAX toward target, -> RAMP.
//   RAMP: each boundary CCR moves min(STEP_MAX,|target-CCR|) toward target; reaching target -> RUN.
//         New target mid-ramp: ramp continues from current CCR toward new target.
//         SLEW_EN dropped mid-ramp: next boundary CCR=target, -> RUN.
//  CCR changes only on boundary edges; never between boundaries.
//  Arithmetic: difference computed at WIDTH+1 bits signed; no overshoot, no wrap;
//   CCR stays in 0..2**WIDTH-1.
//  PWM (registered, 1-cycle latency from TCR): raw = (TCR < CCR) in RUN/RAMP, 0 in SYNC;
//   PWM = raw ^ INVERT. CCR=0 -> never active; CCR=2**WIDTH-1 -> active 127 of 128 counts.
//   Compare uses CCR value registered before the edge, so boundary period uses new CCR from TCR==1 on.
//  BUSY = (state==RAMP), registered.
// STRUCTURE
//  Shared package pwm_pkg: WIDTH default, state encoding SYNC/RUN/RAMP, STEP_MAX default.
//  Sub-module pwm_slew_step (combinational): in CCR, target, STEP_MAX, SLEW_EN ->
//   next CCR, done flag. All registers, FSM, handshake, compare stay in pwm_ccr_out.
// TESTING (bench drives TCR/E from a synchronous 7-bit counter, E=(TCR==0))
//  1 Reset, no requests -> PWM=0 all cycles, DUTY_READY=1, CCR=0, one PERIOD_DONE per 128 cycles.
//  2 SLEW_EN=0, write 32 mid-period -> READY low until boundary; CCR=32 after boundary;
//    PWM high exactly 32 cycles/period.
//  3 SLEW_EN=1, STEP_MAX=8, 0 -> 100: CCR 8,16,...,96,100 on successive boundaries;
//    BUSY high until CCR=100, then RUN.
//  4 Write lands on boundary edge -> not applied this boundary, applied next;
//    second write while READY=0 ignored.
//  5 Write 127 then 0 (SLEW_EN=0) -> 127 high cycles/period, then PWM constantly 0;
//    INVERT=1 build gives complement.
//  6 RST asserted mid-ramp (CCR=40, target=100) -> next cycle all outputs at reset values,
//    state SYNC, PWM inactive until first boundary.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM compare/output stage.
package pwm_pkg;

   localparam int PWM_WIDTH    = 7;
   localparam int PWM_STEP_MAX = 8;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      RUN  = 2'd1,
      RAMP = 2'd2
   } pwm_state_t;

endpackage

// File: rtl/pwm_slew_step.sv
// One period's worth of CCR movement toward target; clamps at target so it never overshoots.
module pwm_slew_step
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic [WIDTH-1:0] ccr,
   input  logic [WIDTH-1:0] tgt,
   input  logic [WIDTH-1:0] step,
   input  logic             slew_en,
   output logic [WIDTH-1:0] ccr_nx,
   output logic             done
);

   logic signed [WIDTH:0] diff;
   logic        [WIDTH:0] mag;

   always_comb begin
      ccr_nx = tgt;
      done   = 1'b1;
      // one extra bit keeps the signed difference exact across the full 0..2**WIDTH-1 range
      diff   = $signed({1'b0, tgt}) - $signed({1'b0, ccr});
      mag    = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      if (slew_en && (mag > {1'b0, step})) begin
         done   = 1'b0;
         ccr_nx = diff[WIDTH] ? (ccr - step) : (ccr + step);
      end
   end

endmodule

// File: rtl/pwm_ccr_out.sv
// Compare/output stage: buffers duty requests, commits them to CCR only on period boundaries, drives PWM.
module pwm_ccr_out
   import pwm_pkg::*;
#(
   parameter int WIDTH    = PWM_WIDTH,
   parameter int STEP_MAX = PWM_STEP_MAX,
   parameter bit INVERT   = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] TCR,
   input  logic             E,
   input  logic [WIDTH-1:0] DUTY_IN,
   input  logic             DUTY_VALID,
   output logic             DUTY_READY,
   input  logic             SLEW_EN,
   output logic [WIDTH-1:0] CCR,
   output logic             PWM,
   output logic             BUSY,
   output logic             PERIOD_DONE
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(STEP_MAX);

   pwm_state_t       state, state_n;
   logic [WIDTH-1:0] ccr_q, tgt_q, pend_q, tgt_nx, step_ccr;
   logic             pend_full, e_q, pwm_q, busy_q, done_q;
   logic             boundary, step_done, pwm_raw;

   // E may stay high for several cycles; only its rising edge marks a period start
   assign boundary = E & ~e_q;
   assign tgt_nx   = pend_full ? pend_q : tgt_q;
   assign pwm_raw  = (state != SYNC) && (TCR < ccr_q);

   pwm_slew_step #(.WIDTH(WIDTH)) u_step (
      .ccr     (ccr_q),
      .tgt     (tgt_nx),
      .step    (STEP),
      .slew_en (SLEW_EN),
      .ccr_nx  (step_ccr),
      .done    (step_done)
   );

   always_comb begin
      state_n = state;
      if (boundary)
         state_n = step_done ? RUN : RAMP;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= SYNC;
      else     state <= state_n;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ccr_q     <= '0;
         tgt_q     <= '0;
         pend_q    <= '0;
         pend_full <= 1'b0;
         e_q       <= 1'b0;
         pwm_q     <= INVERT;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         e_q    <= E;
         done_q <= boundary;
         pwm_q  <= pwm_raw ^ INVERT;
         busy_q <= (state_n == RAMP);
         if (boundary) begin
            ccr_q <= step_ccr;
            tgt_q <= tgt_nx;
         end
         // a request accepted on a boundary edge is held for the following boundary
         if (boundary && pend_full) begin
            pend_full <= 1'b0;
         end else if (DUTY_VALID && !pend_full) begin
            pend_full <= 1'b1;
            pend_q    <= DUTY_IN;
         end
      end
   end

   assign DUTY_READY  = ~pend_full;
   assign CCR         = ccr_q;
   assign PWM         = pwm_q;
   assign BUSY        = busy_q;
   assign PERIOD_DONE = done_q;

endmodule

// File: tb/tb_pwm_ccr_out.sv
// Bench for pwm_ccr_out: per-cycle reference model, duty table, and directed corner sequences.
module tb_pwm_ccr_out;

   localparam int SM = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] TCR = 7'd0;
   logic       E;
   logic [6:0] DUTY_IN = 7'd0;
   logic       DUTY_VALID = 1'b0;
   logic       SLEW_EN = 1'b0;
   logic       DUTY_READY, PWM, BUSY, PERIOD_DONE;
   logic [6:0] CCR;
   logic       rdy_i, pwm_i, busy_i, pd_i;
   logic [6:0] ccr_i;

   pwm_ccr_out #(.WIDTH(7), .STEP_MAX(SM), .INVERT(1'b0)) u_dut (
      .CLK(CLK), .RST(RST), .TCR(TCR), .E(E), .DUTY_IN(DUTY_IN), .DUTY_VALID(DUTY_VALID),
      .DUTY_READY(DUTY_READY), .SLEW_EN(SLEW_EN), .CCR(CCR), .PWM(PWM), .BUSY(BUSY),
      .PERIOD_DONE(PERIOD_DONE));

   pwm_ccr_out #(.WIDTH(7), .STEP_MAX(SM), .INVERT(1'b1)) u_inv (
      .CLK(CLK), .RST(RST), .TCR(TCR), .E(E), .DUTY_IN(DUTY_IN), .DUTY_VALID(DUTY_VALID),
      .DUTY_READY(rdy_i), .SLEW_EN(SLEW_EN), .CCR(ccr_i), .PWM(pwm_i), .BUSY(busy_i),
      .PERIOD_DONE(pd_i));

   always #5 CLK = ~CLK;
   assign E = (TCR == 7'd0);

   initial forever begin
      @(negedge CLK);
      TCR = TCR + 7'd1;
   end

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: integers and flags updated from the rules, one step per clock edge
   int m_ccr = 0, m_tgt = 0, m_pend = 0;
   bit m_pfull = 0, m_sync = 1, m_eprev = 0, m_pd = 0, m_raw = 0;

   initial begin : model
      bit bnd, rdy;
      int d;
      forever begin
         @(posedge CLK);
         if (RST) begin
            m_ccr = 0; m_tgt = 0; m_pend = 0; m_pfull = 0;
            m_sync = 1; m_eprev = 0; m_pd = 0; m_raw = 0;
         end else begin
            bnd     = E && !m_eprev;
            m_eprev = E;
            rdy     = !m_pfull;
            m_raw   = !m_sync && (int'(TCR) < m_ccr);
            m_pd    = bnd;
            if (bnd) begin
               if (m_pfull) begin
                  m_tgt   = m_pend;
                  m_pfull = 0;
               end
               m_sync = 0;
               d = m_tgt - m_ccr;
               if (!SLEW_EN || (d <= SM && d >= -SM)) m_ccr = m_tgt;
               else m_ccr = m_ccr + ((d > 0) ? SM : -SM);
            end
            if (DUTY_VALID && rdy) begin
               m_pfull = 1;
               m_pend  = int'(DUTY_IN);
            end
         end
      end
   end

   initial forever begin
      @(negedge CLK);
      if (chk_en) begin
         check("ccr",         CCR,         m_ccr);
         check("ready",       DUTY_READY,  !m_pfull);
         check("busy",        BUSY,        m_ccr != m_tgt);
         check("period_done", PERIOD_DONE, m_pd);
         check("pwm",         PWM,         m_raw);
         check("pwm_inv",     pwm_i,       !m_raw);
      end
   end

   task automatic wait_tcr(input int k);
      int n = 0;
      do begin
         @(posedge CLK);
         n++;
      end while (int'(TCR) != k && n < 300);
      if (n >= 300) check("timeout_wait_tcr", 0, 1);
      #1;
   endtask

   task automatic write(input int d);
      int n = 0;
      @(negedge CLK);
      DUTY_IN    = 7'(d);
      DUTY_VALID = 1'b1;
      while (!DUTY_READY && n < 300) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 300) check("timeout_write", 0, 1);
      @(negedge CLK);
      DUTY_VALID = 1'b0;
   endtask

   task automatic count_high(output int h, output int hi);
      h = 0; hi = 0;
      repeat (128) begin
         @(negedge CLK);
         h  += int'(PWM);
         hi += int'(pwm_i);
      end
   endtask

   typedef struct {
      int duty;
      bit slew;
      int exp_high;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int h, hi, cnt;
      tbl[0] = '{32, 1'b0, 32};
      tbl[1] = '{127, 1'b0, 127};
      tbl[2] = '{0, 1'b0, 0};
      tbl[3] = '{64, 1'b1, 64};
      tbl[4] = '{100, 1'b1, 100};
      tbl[5] = '{1, 1'b0, 1};

      repeat (3) @(negedge CLK);
      chk_en = 1'b1;
      check("reset_ccr", CCR, 0);
      check("reset_pwm_inv", pwm_i, 1);
      RST = 1'b0;

      // idle: one PERIOD_DONE every 128 cycles, outputs quiet
      cnt = 0;
      repeat (256) begin
         @(negedge CLK);
         cnt += int'(PERIOD_DONE);
      end
      check("idle_period_done", cnt, 2);
      check("idle_ready", DUTY_READY, 1);
      check("idle_ccr", CCR, 0);

      // jump to 32 mid-period
      SLEW_EN = 1'b0;
      wait_tcr(40);
      write(32);
      #1 check("jump_ready_low", DUTY_READY, 0);
      wait_tcr(5);
      check("jump_ccr", CCR, 32);
      wait_tcr(10);
      count_high(h, hi);
      check("jump_high", h, 32);

      // ramp 0 -> 100 in steps of 8
      write(0);
      wait_tcr(3);
      check("ramp_start_ccr", CCR, 0);
      SLEW_EN = 1'b1;
      wait_tcr(40);
      write(100);
      for (int k = 1; k <= 13; k++) begin
         wait_tcr(3);
         check("ramp_ccr", CCR, (k < 13) ? 8 * k : 100);
         check("ramp_busy", BUSY, (k < 13) ? 1 : 0);
      end

      // request landing on the boundary edge waits a full period; request while busy ignored
      SLEW_EN = 1'b0;
      wait_tcr(127);
      @(negedge CLK);
      DUTY_IN    = 7'd20;
      DUTY_VALID = 1'b1;
      @(negedge CLK);
      DUTY_VALID = 1'b0;
      wait_tcr(5);
      check("edge_not_applied", CCR, 100);
      check("edge_ready_low", DUTY_READY, 0);
      @(negedge CLK);
      DUTY_IN    = 7'd90;
      DUTY_VALID = 1'b1;
      repeat (10) @(negedge CLK);
      DUTY_VALID = 1'b0;
      wait_tcr(5);
      check("edge_applied", CCR, 20);
      wait_tcr(5);
      check("edge_second_ignored", CCR, 20);
      check("edge_ready_back", DUTY_READY, 1);

      // steady-state duty table, normal and inverted outputs
      for (int i = 0; i < 6; i++) begin
         SLEW_EN = tbl[i].slew;
         wait_tcr(40);
         write(tbl[i].duty);
         repeat (17) wait_tcr(10);
         count_high(h, hi);
         check("tbl_high", h, tbl[i].exp_high);
         check("tbl_high_inv", hi, 128 - tbl[i].exp_high);
      end

      // reset in the middle of a ramp
      SLEW_EN = 1'b0;
      wait_tcr(40);
      write(0);
      wait_tcr(10);
      SLEW_EN = 1'b1;
      write(100);
      repeat (5) wait_tcr(3);
      check("midramp_ccr", CCR, 40);
      check("midramp_busy", BUSY, 1);
      wait_tcr(50);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("rst_ccr", CCR, 0);
      check("rst_busy", BUSY, 0);
      check("rst_ready", DUTY_READY, 1);
      check("rst_pwm", PWM, 0);
      check("rst_pwm_inv", pwm_i, 1);
      check("rst_done", PERIOD_DONE, 0);
      wait_tcr(2);
      check("rst_ccr_after", CCR, 0);

      // random traffic against the model
      repeat (3000) begin
         @(negedge CLK);
         DUTY_VALID = ($urandom_range(0, 3) == 0);
         DUTY_IN    = 7'($urandom);
         if ($urandom_range(0, 199) == 0) SLEW_EN = ~SLEW_EN;
         RST = ($urandom_range(0, 999) == 0);
      end
      @(negedge CLK);
      RST = 1'b0;
      DUTY_VALID = 1'b0;
      repeat (4) @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
